// File: rtl/subservient_sram_loader.sv
// Boot-time SRAM loader: streams an image into SRAM from address 0, optionally
// verifies it by readback checksum, then releases the core and hands it the SRAM port.
module subservient_sram_loader #(
    parameter int memsize     = 1024,
    parameter bit WITH_VERIFY = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [7:0]                  i_load_data,
    input  logic                        i_load_valid,
    input  logic                        i_load_last,
    output logic                        o_load_ready,
    input  logic [$clog2(memsize)-1:0]  i_core_waddr,
    input  logic [7:0]                  i_core_wdata,
    input  logic                        i_core_wen,
    input  logic [$clog2(memsize)-1:0]  i_core_raddr,
    input  logic                        i_core_ren,
    output logic [7:0]                  o_core_rdata,
    output logic [$clog2(memsize)-1:0]  o_sram_waddr,
    output logic [7:0]                  o_sram_wdata,
    output logic                        o_sram_wen,
    output logic [$clog2(memsize)-1:0]  o_sram_raddr,
    output logic                        o_sram_ren,
    input  logic [7:0]                  i_sram_rdata,
    output logic                        o_core_rst,
    output logic                        o_done,
    output logic                        o_error
);

    localparam int unsigned aw = $clog2(memsize);

    typedef enum logic [1:0] {
        S_LOAD,
        S_VERIFY,
        S_RUN,
        S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [aw-1:0]  addr_q;
    logic [aw:0]    count_q;
    logic [aw:0]    vidx_q;
    logic [7:0]     sum_q;
    logic [7:0]     vsum_q;
    logic [7:0]     vsum_nxt;
    logic           rd_pend_q;
    logic           load_hs;
    logic           core_rst_q;
    logic           done_q;
    logic           error_q;

    assign o_core_rdata = i_sram_rdata;
    assign o_core_rst   = core_rst_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational SRAM mux and load handshake.
    always_comb begin
        state_d      = state_q;
        load_hs      = 1'b0;
        o_load_ready = 1'b0;
        o_sram_waddr = '0;
        o_sram_wdata = '0;
        o_sram_wen   = 1'b0;
        o_sram_raddr = '0;
        o_sram_ren   = 1'b0;
        vsum_nxt     = vsum_q + (rd_pend_q ? i_sram_rdata : 8'd0);

        case (state_q)
            S_LOAD: begin
                o_load_ready = 1'b1;
                if (i_load_valid) begin
                    load_hs      = 1'b1;
                    o_sram_waddr = addr_q;
                    o_sram_wdata = i_load_data;
                    o_sram_wen   = 1'b1;
                    if (i_load_last) begin
                        state_d = WITH_VERIFY ? S_VERIFY : S_RUN;
                    end else if (addr_q == aw'(memsize - 1)) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_VERIFY: begin
                // Final cycle folds the last read's data in combinationally and decides.
                if (vidx_q != count_q) begin
                    o_sram_raddr = vidx_q[aw-1:0];
                    o_sram_ren   = 1'b1;
                end else begin
                    state_d = (vsum_nxt == sum_q) ? S_RUN : S_ERROR;
                end
            end
            S_RUN: begin
                o_sram_waddr = i_core_waddr;
                o_sram_wdata = i_core_wdata;
                o_sram_wen   = i_core_wen;
                o_sram_raddr = i_core_raddr;
                o_sram_ren   = i_core_ren;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        if (i_rst) begin
            state_d      = S_LOAD;
            load_hs      = 1'b0;
            o_load_ready = 1'b0;
            o_sram_wen   = 1'b0;
            o_sram_ren   = 1'b0;
        end
    end

    // Load/verify datapath and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q     <= '0;
            count_q    <= '0;
            vidx_q     <= '0;
            sum_q      <= '0;
            vsum_q     <= '0;
            rd_pend_q  <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (load_hs) begin
                addr_q  <= addr_q + aw'(1);
                count_q <= count_q + (aw + 1)'(1);
                sum_q   <= sum_q + i_load_data;
            end
            rd_pend_q <= o_sram_ren && (state_q == S_VERIFY);
            if (state_q == S_VERIFY) begin
                vsum_q <= vsum_nxt;
                if (o_sram_ren) begin
                    vidx_q <= vidx_q + (aw + 1)'(1);
                end
            end
            core_rst_q <= (state_q != S_RUN);
            done_q     <= (state_q == S_RUN);
            error_q    <= (state_q == S_ERROR);
        end
    end

endmodule

// File: tb/tb_subservient_sram_loader.sv
// Directed bench for subservient_sram_loader: three instances (1024/verify,
// 16/no-verify, 16/verify) share one stimulus stream, each with its own SRAM model.
module tb_subservient_sram_loader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] load_data;
    logic       load_valid, load_last;
    logic [9:0] core_waddr, core_raddr;
    logic [7:0] core_wdata;
    logic       core_wen, core_ren;
    logic       corrupt = 1'b0;

    logic       ready_a, swen_a, sren_a, crst_a, done_a, err_a;
    logic [9:0] sw_a, sr_a;
    logic [7:0] swd_a, srd_a, crd_a;
    logic       ready_b, swen_b, sren_b, crst_b, done_b, err_b;
    logic [3:0] sw_b, sr_b;
    logic [7:0] swd_b, srd_b, crd_b;
    logic       ready_c, swen_c, sren_c, crst_c, done_c, err_c;
    logic [3:0] sw_c, sr_c;
    logic [7:0] swd_c, srd_c, crd_c;

    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:15];
    logic [7:0] mem_c [0:15];

    int checks = 0;
    int errors = 0;
    int ren_b_cnt = 0;

    subservient_sram_loader #(.memsize(1024), .WITH_VERIFY(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_load_data(load_data), .i_load_valid(load_valid), .i_load_last(load_last),
        .o_load_ready(ready_a),
        .i_core_waddr(core_waddr), .i_core_wdata(core_wdata), .i_core_wen(core_wen),
        .i_core_raddr(core_raddr), .i_core_ren(core_ren), .o_core_rdata(crd_a),
        .o_sram_waddr(sw_a), .o_sram_wdata(swd_a), .o_sram_wen(swen_a),
        .o_sram_raddr(sr_a), .o_sram_ren(sren_a), .i_sram_rdata(srd_a),
        .o_core_rst(crst_a), .o_done(done_a), .o_error(err_a)
    );

    subservient_sram_loader #(.memsize(16), .WITH_VERIFY(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_load_data(load_data), .i_load_valid(load_valid), .i_load_last(load_last),
        .o_load_ready(ready_b),
        .i_core_waddr(core_waddr[3:0]), .i_core_wdata(core_wdata), .i_core_wen(core_wen),
        .i_core_raddr(core_raddr[3:0]), .i_core_ren(core_ren), .o_core_rdata(crd_b),
        .o_sram_waddr(sw_b), .o_sram_wdata(swd_b), .o_sram_wen(swen_b),
        .o_sram_raddr(sr_b), .o_sram_ren(sren_b), .i_sram_rdata(srd_b),
        .o_core_rst(crst_b), .o_done(done_b), .o_error(err_b)
    );

    subservient_sram_loader #(.memsize(16), .WITH_VERIFY(1'b1)) dut_c (
        .i_clk(clk), .i_rst(rst),
        .i_load_data(load_data), .i_load_valid(load_valid), .i_load_last(load_last),
        .o_load_ready(ready_c),
        .i_core_waddr(core_waddr[3:0]), .i_core_wdata(core_wdata), .i_core_wen(core_wen),
        .i_core_raddr(core_raddr[3:0]), .i_core_ren(core_ren), .o_core_rdata(crd_c),
        .o_sram_waddr(sw_c), .o_sram_wdata(swd_c), .o_sram_wen(swen_c),
        .o_sram_raddr(sr_c), .o_sram_ren(sren_c), .i_sram_rdata(srd_c),
        .o_core_rst(crst_c), .o_done(done_c), .o_error(err_c)
    );

    // Byte-wide SRAM models, read data one cycle after ren; dut_a can corrupt address 2.
    always @(posedge clk) begin
        if (swen_a) mem_a[sw_a] <= swd_a;
        if (sren_a) srd_a <= (corrupt && sr_a == 10'd2) ? 8'hFF : mem_a[sr_a];
        if (swen_b) mem_b[sw_b] <= swd_b;
        if (sren_b) srd_b <= mem_b[sr_b];
        if (swen_c) mem_c[sw_c] <= swd_c;
        if (sren_c) srd_c <= mem_c[sr_c];
        if (sren_b) ren_b_cnt <= ren_b_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0;
        core_wen = 1'b0; core_ren = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        load_data = d; load_last = l; load_valid = 1'b1;
        tick;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] img [4];
        int         a;
        int         n;
        int         ren_base;
        img = '{8'h13, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 1024; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin mem_b[i] = 8'h00; mem_c[i] = 8'h00; end
        core_waddr = '0; core_raddr = '0; core_wdata = '0; core_wen = 1'b0; core_ren = 1'b0;
        load_data = 8'h00; load_last = 1'b0;

        // Reset state, with a valid byte offered during reset
        rst = 1'b1; load_valid = 1'b1;
        tick; tick;
        check("rst_core_rst", crst_a, 1);
        check("rst_done", done_a, 0);
        check("rst_error", err_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_wen", swen_a, 0);
        check("rst_ren", sren_a, 0);
        load_valid = 1'b0; rst = 1'b0;
        #1;
        check("load_ready", ready_a, 1);

        // Four-byte image, verify, then core pass-through
        for (int i = 0; i < 4; i++) begin
            load_data = img[i]; load_last = (i == 3); load_valid = 1'b1;
            #1;
            check("s1_waddr", sw_a, i);
            check("s1_wen", swen_a, 1);
            tick;
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("s1_vren", sren_a, (k < 4) ? 1 : 0);
            if (k < 4) check("s1_vraddr", sr_a, k);
            check("s1_vready", ready_a, 0);
            tick;
        end
        check("s1_done_lag", done_a, 0);
        tick;
        check("s1_done", done_a, 1);
        check("s1_core_rst", crst_a, 0);
        check("s1_run_ready", ready_a, 0);
        check("s1_mem0", mem_a[0], 8'h13);
        core_waddr = 10'h155; core_wdata = 8'h5A; core_wen = 1'b1;
        core_raddr = 10'h000; core_ren = 1'b1;
        #1;
        check("s1_pt_waddr", sw_a, 10'h155);
        check("s1_pt_wdata", swd_a, 8'h5A);
        check("s1_pt_wen", swen_a, 1);
        check("s1_pt_raddr", sr_a, 0);
        check("s1_pt_ren", sren_a, 1);
        tick;
        core_wen = 1'b0; core_ren = 1'b0;
        #1;
        check("s1_core_rdata", crd_a, 8'h13);
        check("s1_core_wr", mem_a[10'h155], 8'h5A);

        // Gapped stream; dut_b (no verify) enters RUN right after the last handshake
        do_reset;
        ren_base = ren_b_cnt;
        a = 0;
        for (int i = 0; i < 5; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = 8'(8'h11 * (a + 1));
            load_last  = (i == 4);
            #1;
            if (load_valid) begin
                check("s2_waddr", sw_a, a);
                check("s2_wen", swen_a, 1);
                check("s2_waddr_b", sw_b, a);
                a++;
            end else begin
                check("s2_gap_wen", swen_a, 0);
            end
            tick;
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("s2_b_done_lag", done_b, 0);
        check("s2_b_core_rst_lag", crst_b, 1);
        tick;
        check("s2_b_done", done_b, 1);
        check("s2_b_core_rst", crst_b, 0);
        check("s2_b_no_ren", ren_b_cnt - ren_base, 0);
        check("s2_mem1", mem_a[1], 8'h22);
        check("s2_mem2", mem_a[2], 8'h33);
        n = 0;
        while (!done_a && n < 20) begin tick; n++; end
        check("s2_a_done", done_a, 1);

        // Corrupted readback
        do_reset;
        corrupt = 1'b1;
        for (int i = 0; i < 4; i++) send(img[i], i == 3);
        repeat (6) tick;
        check("s3_error", err_a, 1);
        check("s3_done", done_a, 0);
        check("s3_core_rst", crst_a, 1);
        check("s3_ready", ready_a, 0);
        load_valid = 1'b1; load_data = 8'h77;
        #1;
        check("s3_no_wen", swen_a, 0);
        tick;
        load_valid = 1'b0;
        check("s3_sticky", err_a, 1);
        corrupt = 1'b0;

        // memsize=16 overflow, then exactly 16 bytes with last
        do_reset;
        for (int i = 0; i < 16; i++) begin
            load_data = 8'(i + 1); load_last = 1'b0; load_valid = 1'b1;
            #1;
            check("s4_waddr", sw_c, i);
            check("s4_wen", swen_c, 1);
            tick;
        end
        load_data = 8'h99; load_valid = 1'b1;
        #1;
        check("s4_ovf_ready", ready_c, 0);
        check("s4_ovf_wen", swen_c, 0);
        tick;
        load_valid = 1'b0;
        check("s4_ovf_error", err_c, 1);
        check("s4_mem15", mem_c[15], 8'h10);
        do_reset;
        for (int i = 0; i < 16; i++) send(8'(i * 7), i == 15);
        n = 0;
        while (!done_c && n < 40) begin tick; n++; end
        check("s4_full_cycles", n, 18);
        check("s4_full_done", done_c, 1);
        check("s4_full_error", err_c, 0);

        // Reset mid-verify, then single-byte image
        do_reset;
        for (int i = 0; i < 4; i++) send(img[i], i == 3);
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        load_data = 8'hAA; load_last = 1'b1; load_valid = 1'b1;
        #1;
        check("s5_waddr", sw_a, 0);
        check("s5_wen", swen_a, 1);
        tick;
        load_valid = 1'b0; load_last = 1'b0;
        check("s5_v0_ren", sren_a, 1);
        check("s5_v0_raddr", sr_a, 0);
        tick;
        check("s5_v1_ren", sren_a, 0);
        tick;
        check("s5_done_lag", done_a, 0);
        tick;
        check("s5_done", done_a, 1);
        check("s5_mem0", mem_a[0], 8'hAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
